// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================
// Package : game_pkg
// Brief   : Judge/result codes and round-sequencer state set.
// Rev     : 1.0
// ============================================================
package game_pkg;

   localparam logic [1:0] WL_NONE  = 2'b00;
   localparam logic [1:0] WL_MINE  = 2'b01;
   localparam logic [1:0] WL_ENEMY = 2'b10;
   localparam logic [1:0] WL_DRAW  = 2'b11;

   // Result codes share the judge encoding so a draw/win maps one-to-one.
   localparam logic [1:0] RES_NONE  = WL_NONE;
   localparam logic [1:0] RES_MINE  = WL_MINE;
   localparam logic [1:0] RES_ENEMY = WL_ENEMY;
   localparam logic [1:0] RES_DRAW  = WL_DRAW;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT_Q = 3'd2,
      ST_ANSWER = 3'd3,
      ST_APPLY  = 3'd4,
      ST_CHECK  = 3'd5,
      ST_OVER   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/battle_round_ctrl_if.sv
`default_nettype none
// ============================================================
// Interface : battle_round_ctrl_if
// Brief     : Question/judge handshake and game status bundle.
// Rev       : 1.0
// ============================================================
interface battle_round_ctrl_if #(
   parameter int HP_W   = 4,
   parameter int TIME_W = 16
);
   logic              start;
   logic              q_req;
   logic              q_ack;
   logic [1:0]        wl_in;
   logic              ans_en;
   logic [TIME_W-1:0] time_left;
   logic [HP_W-1:0]   hp_mine;
   logic [HP_W-1:0]   hp_enemy;
   logic [3:0]        round;
   logic [1:0]        result;
   logic              busy;

   modport master (
      input  start, q_ack, wl_in,
      output q_req, ans_en, time_left, hp_mine, hp_enemy, round, result, busy
   );

   modport slave (
      output start, q_ack, wl_in,
      input  q_req, ans_en, time_left, hp_mine, hp_enemy, round, result, busy
   );
endinterface
`default_nettype wire

// File: rtl/round_timer.sv
`default_nettype none
// ============================================================
// Module : round_timer
// Brief  : Loadable down-counter with zero flag for the answer window.
// Rev    : 1.0
// ============================================================
module round_timer #(
   parameter int TIME_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              dec,
   output logic [TIME_W-1:0] count,
   output logic              zero
);
   logic [TIME_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - TIME_W'(1);
      end
   end

   assign count = r_count;
   assign zero  = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/battle_round_ctrl.sv
`default_nettype none
// ============================================================
// Module : battle_round_ctrl
// Brief  : Round sequencer: question request, timed answer, HP damage, result.
// Rev    : 1.0
// ============================================================
module battle_round_ctrl
   import game_pkg::*;
#(
   parameter int HP_INIT    = 5,
   parameter int HP_W       = 4,
   parameter int TIME_LIMIT = 1000,
   parameter int TIME_W     = 16,
   parameter int MAX_ROUND  = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   battle_round_ctrl_if.master bus
);
   localparam logic [HP_W-1:0]   c_hp_init    = HP_W'(HP_INIT);
   localparam logic [TIME_W-1:0] c_time_limit = TIME_W'(TIME_LIMIT);
   localparam logic [3:0]        c_max_round  = 4'(MAX_ROUND);

   state_t            r_state, w_state_nx;
   logic [HP_W-1:0]   r_hp_mine, w_hp_mine_nx;
   logic [HP_W-1:0]   r_hp_enemy, w_hp_enemy_nx;
   logic [3:0]        r_round, w_round_nx;
   logic [1:0]        r_result, w_result_nx;
   logic [1:0]        r_wl_cap, w_wl_cap_nx;
   logic              w_tmr_load, w_tmr_dec, w_tmr_zero;
   logic [TIME_W-1:0] w_time_left;

   round_timer #(.TIME_W(TIME_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_tmr_load),
      .load_val (c_time_limit),
      .dec      (w_tmr_dec),
      .count    (w_time_left),
      .zero     (w_tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_hp_mine  <= c_hp_init;
         r_hp_enemy <= c_hp_init;
         r_round    <= 4'd0;
         r_result   <= RES_NONE;
         r_wl_cap   <= WL_NONE;
      end else begin
         r_state    <= w_state_nx;
         r_hp_mine  <= w_hp_mine_nx;
         r_hp_enemy <= w_hp_enemy_nx;
         r_round    <= w_round_nx;
         r_result   <= w_result_nx;
         r_wl_cap   <= w_wl_cap_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_hp_mine_nx  = r_hp_mine;
      w_hp_enemy_nx = r_hp_enemy;
      w_round_nx    = r_round;
      w_result_nx   = r_result;
      w_wl_cap_nx   = r_wl_cap;
      w_tmr_load    = 1'b0;
      w_tmr_dec     = 1'b0;
      case (r_state)
         ST_IDLE, ST_OVER: begin
            if (bus.start) begin
               w_state_nx    = ST_REQ;
               w_hp_mine_nx  = c_hp_init;
               w_hp_enemy_nx = c_hp_init;
               w_round_nx    = 4'd0;
               w_result_nx   = RES_NONE;
            end
         end
         ST_REQ: w_state_nx = ST_WAIT_Q;
         ST_WAIT_Q: begin
            if (bus.q_ack) begin
               w_state_nx = ST_ANSWER;
               w_tmr_load = 1'b1;
            end
         end
         ST_ANSWER: begin
            // A verdict on the last window cycle beats the timeout.
            if (bus.wl_in != WL_NONE) begin
               w_wl_cap_nx = bus.wl_in;
               w_state_nx  = ST_APPLY;
            end else if (w_tmr_zero) begin
               w_wl_cap_nx = WL_NONE;
               w_state_nx  = ST_APPLY;
            end else begin
               w_tmr_dec = 1'b1;
            end
         end
         ST_APPLY: begin
            // Bit 1 of the code hits own HP, bit 0 hits the enemy.
            if (r_wl_cap[1] && (r_hp_mine != '0))  w_hp_mine_nx  = r_hp_mine - HP_W'(1);
            if (r_wl_cap[0] && (r_hp_enemy != '0)) w_hp_enemy_nx = r_hp_enemy - HP_W'(1);
            if (r_round != 4'd15) w_round_nx = r_round + 4'd1;
            w_state_nx = ST_CHECK;
         end
         ST_CHECK: begin
            w_state_nx = ST_OVER;
            if ((r_hp_mine == '0) && (r_hp_enemy == '0))  w_result_nx = RES_DRAW;
            else if (r_hp_mine == '0)                     w_result_nx = RES_ENEMY;
            else if (r_hp_enemy == '0)                    w_result_nx = RES_MINE;
            else if (r_round == c_max_round) begin
               if (r_hp_mine > r_hp_enemy)      w_result_nx = RES_MINE;
               else if (r_hp_mine < r_hp_enemy) w_result_nx = RES_ENEMY;
               else                             w_result_nx = RES_DRAW;
            end else begin
               w_state_nx = ST_REQ;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   assign bus.q_req     = (r_state == ST_REQ);
   assign bus.ans_en    = (r_state == ST_ANSWER);
   assign bus.busy      = (r_state != ST_IDLE) && (r_state != ST_OVER);
   assign bus.time_left = w_time_left;
   assign bus.hp_mine   = r_hp_mine;
   assign bus.hp_enemy  = r_hp_enemy;
   assign bus.round     = r_round;
   assign bus.result    = r_result;
endmodule
`default_nettype wire
